sound_scheduler: RTL

Upstream sequencer for the audio path. It turns one-cycle game sound-event requests into the `select`/`onOff` controls of the I2S player. It also drives the player's `nReset` so that every new sound starts from word 0 with a cleared repeat count. Background theme (select 0) plays whenever no effect is queued. Effects are buffered in a small FIFO and played one at a time, each to completion, using the player's `theme_ended` pulse.

---
 rtl/sound_scheduler.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sound_scheduler.sv
// -----------------------------------------------------------------------------
// sound_scheduler
//
// Upstream sequencer for the I2S audio player. It turns one-cycle game
// sound-event requests into player controls. The background theme (id 0)
// plays whenever no effect is waiting. Effects are buffered in a small FIFO
// and played one at a time, each to completion. Before every new sound the
// player is held in reset for a fixed number of cycles, so playback starts
// from word 0 with a cleared repeat count.
//
// Ports:
//   MCLK           in   system clock
//   nReset         in   synchronous active-low reset
//   enable         in   sound enable; 0 mutes the output and flushes the queue
//   event_req[7:0] in   bit i requests sound id i (bits 7..1); bit 0 is unused
//   theme_ended    in   one-cycle pulse from the player at the end of each pass
//   select[3:0]    out  sound id to the player, {1'b0, id}
//   onOff          out  player transmit enable
//   player_nReset  out  active-low restart to the player
//   busy           out  an effect is playing, restarting or queued
//   queue_full     out  FIFO holds QUEUE_DEPTH entries
//   dropped        out  one-cycle pulse when a request was discarded
// -----------------------------------------------------------------------------
module sound_scheduler #(
  parameter int QUEUE_DEPTH    = 4,
  parameter int RESTART_CYCLES = 4
) (
  input  logic       MCLK,
  input  logic       nReset,
  input  logic       enable,
  input  logic [7:0] event_req,
  input  logic       theme_ended,
  output logic [3:0] select,
  output logic       onOff,
  output logic       player_nReset,
  output logic       busy,
  output logic       queue_full,
  output logic       dropped
);

  localparam int PW  = $clog2(QUEUE_DEPTH);
  localparam int CW  = PW + 1;
  localparam int RCW = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;

  localparam logic [CW-1:0]  FULL_C   = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0]  EMPTY_C  = {CW{1'b0}};
  localparam logic [PW-1:0]  PTR0_C   = {PW{1'b0}};
  localparam logic [PW-1:0]  PTR1_C   = PW'(1);
  localparam logic [CW-1:0]  CNT1_C   = CW'(1);
  localparam logic [RCW-1:0] RCNT0_C  = {RCW{1'b0}};
  localparam logic [RCW-1:0] RCNT1_C  = RCW'(1);
  localparam logic [RCW-1:0] RLAST_C  = RCW'(RESTART_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RESTART = 2'd0,
    ST_THEME   = 2'd1,
    ST_EFFECT  = 2'd2,
    ST_MUTE    = 2'd3
  } state_t;

  // Registers
  state_t         state_r;
  logic           target_effect_r;
  logic [RCW-1:0] rcnt_r;
  logic [3:0]     select_r;
  logic           onoff_r;
  logic           pnr_r;
  logic           busy_r;
  logic           queue_full_r;
  logic           dropped_r;
  logic [7:0]     req_q_r;
  logic [2:0]     mem_r [QUEUE_DEPTH];
  logic [PW-1:0]  wr_ptr_r;
  logic [PW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;

  // Combinational helpers
  logic [7:0]    rise_s;
  logic [6:0]    eff_rise_s;
  logic [2:0]    cand_id_s;
  logic          cand_valid_s;
  logic          multi_s;
  logic          not_empty_s;
  logic          is_full_s;
  logic          pop_s;
  logic          wr_s;
  logic          drop_s;
  logic [CW-1:0] count_next_s;
  logic [2:0]    head_s;
  logic          unused_req0_s;

  // Bit 0 would request the theme, which is implicit, so it never enqueues.
  assign unused_req0_s = rise_s[0];

  assign rise_s      = event_req & ~req_q_r;
  assign eff_rise_s  = rise_s[7:1];
  // More than one effect bit rising in the same cycle: all but the top one are lost.
  assign multi_s     = |(eff_rise_s & (eff_rise_s - 7'd1));
  assign not_empty_s = (count_r != EMPTY_C);
  assign is_full_s   = (count_r == FULL_C);
  assign head_s      = mem_r[rd_ptr_r];

  // A pop happens exactly when the FSM leaves a play state to start a queued effect.
  assign pop_s  = enable & not_empty_s &
                  ((state_r == ST_THEME) | ((state_r == ST_EFFECT) & theme_ended));
  // A full FIFO still accepts a write when a pop frees a slot on the same edge.
  assign wr_s   = enable & cand_valid_s & (~is_full_s | pop_s);
  assign drop_s = enable & cand_valid_s & (multi_s | (is_full_s & ~pop_s));

  // Highest-index rising effect request is the enqueue candidate
  always_comb begin
    cand_id_s    = 3'd0;
    cand_valid_s = 1'b1;
    casez (eff_rise_s)
      7'b1??????: cand_id_s = 3'd7;
      7'b01?????: cand_id_s = 3'd6;
      7'b001????: cand_id_s = 3'd5;
      7'b0001???: cand_id_s = 3'd4;
      7'b00001??: cand_id_s = 3'd3;
      7'b000001?: cand_id_s = 3'd2;
      7'b0000001: cand_id_s = 3'd1;
      default:    cand_valid_s = 1'b0;
    endcase
  end

  // Next FIFO occupancy; disabling sound empties the queue
  always_comb begin
    count_next_s = count_r;
    if (!enable) begin
      count_next_s = EMPTY_C;
    end else if (wr_s && !pop_s) begin
      count_next_s = count_r + CNT1_C;
    end else if (!wr_s && pop_s) begin
      count_next_s = count_r - CNT1_C;
    end else begin
      count_next_s = count_r;
    end
  end

  // FIFO storage; entries need no reset because count gates every read
  always_ff @(posedge MCLK) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= cand_id_s;
    end
  end

  // FIFO pointers, occupancy, request edge history and drop/full flags
  always_ff @(posedge MCLK) begin
    if (!nReset) begin
      wr_ptr_r     <= PTR0_C;
      rd_ptr_r     <= PTR0_C;
      count_r      <= EMPTY_C;
      queue_full_r <= 1'b0;
      dropped_r    <= 1'b0;
      req_q_r      <= 8'd0;
    end else begin
      req_q_r      <= event_req;
      dropped_r    <= drop_s;
      count_r      <= count_next_s;
      queue_full_r <= (count_next_s == FULL_C);
      if (!enable) begin
        wr_ptr_r <= PTR0_C;
        rd_ptr_r <= PTR0_C;
      end else begin
        if (wr_s) begin
          wr_ptr_r <= wr_ptr_r + PTR1_C;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR1_C;
        end
      end
    end
  end

  // Playback FSM: restart sequencing, sound selection and all player controls
  always_ff @(posedge MCLK) begin
    if (!nReset) begin
      state_r         <= ST_RESTART;
      target_effect_r <= 1'b0;
      rcnt_r          <= RCNT0_C;
      select_r        <= 4'd0;
      onoff_r         <= 1'b0;
      pnr_r           <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      // Branches that leave the FSM in an effect-related state override this.
      busy_r <= (count_next_s != EMPTY_C);
      case (state_r)
        ST_RESTART: begin
          if (rcnt_r == RLAST_C) begin
            rcnt_r <= RCNT0_C;
            pnr_r  <= 1'b1;
            if (!enable) begin
              state_r <= ST_MUTE;
              onoff_r <= 1'b0;
            end else if (target_effect_r) begin
              state_r <= ST_EFFECT;
              onoff_r <= 1'b1;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_THEME;
              onoff_r <= 1'b1;
            end
          end else begin
            rcnt_r  <= rcnt_r + RCNT1_C;
            pnr_r   <= 1'b0;
            onoff_r <= 1'b0;
            busy_r  <= target_effect_r | (count_next_s != EMPTY_C);
          end
        end

        ST_THEME: begin
          if (!enable) begin
            state_r <= ST_MUTE;
            onoff_r <= 1'b0;
            pnr_r   <= 1'b1;
          end else if (not_empty_s) begin
            select_r        <= {1'b0, head_s};
            state_r         <= ST_RESTART;
            target_effect_r <= 1'b1;
            rcnt_r          <= RCNT0_C;
            onoff_r         <= 1'b0;
            pnr_r           <= 1'b0;
            busy_r          <= 1'b1;
          end else begin
            select_r <= 4'd0;
            onoff_r  <= 1'b1;
            pnr_r    <= 1'b1;
          end
        end

        ST_EFFECT: begin
          if (!enable) begin
            state_r <= ST_MUTE;
            onoff_r <= 1'b0;
            pnr_r   <= 1'b1;
          end else if (theme_ended) begin
            state_r <= ST_RESTART;
            rcnt_r  <= RCNT0_C;
            onoff_r <= 1'b0;
            pnr_r   <= 1'b0;
            if (not_empty_s) begin
              select_r        <= {1'b0, head_s};
              target_effect_r <= 1'b1;
              busy_r          <= 1'b1;
            end else begin
              select_r        <= 4'd0;
              target_effect_r <= 1'b0;
            end
          end else begin
            onoff_r <= 1'b1;
            pnr_r   <= 1'b1;
            busy_r  <= 1'b1;
          end
        end

        ST_MUTE: begin
          onoff_r <= 1'b0;
          if (enable) begin
            select_r        <= 4'd0;
            state_r         <= ST_RESTART;
            target_effect_r <= 1'b0;
            rcnt_r          <= RCNT0_C;
            pnr_r           <= 1'b0;
          end else begin
            pnr_r <= 1'b1;
          end
        end

        default: begin
          state_r         <= ST_RESTART;
          target_effect_r <= 1'b0;
          rcnt_r          <= RCNT0_C;
          select_r        <= 4'd0;
          onoff_r         <= 1'b0;
          pnr_r           <= 1'b0;
        end
      endcase
    end
  end

  assign select        = select_r;
  assign onOff         = onoff_r;
  assign player_nReset = pnr_r;
  assign busy          = busy_r;
  assign queue_full    = queue_full_r;
  assign dropped       = dropped_r;

endmodule
